text_grid_display: RTL and testbench
====================================

Name: text_grid_display

Overview:
- Parametrised successor to the 8x8 digit-grid display: a character-cell text display with internal single-port character RAM.
- Host writes go through a command handshake with cursor auto-advance, plus a hardware clear-screen engine.
- Sits between hvsync_generator and an external combinational glyph ROM; drives a 1-bit pixel into the colour mux.

Parameters:
- COLS, 32, text columns (1..64)
- ROWS, 30, text rows (1..64)
- CELL_W_LOG2, 3, log2 cell width in pixels (cell width = 8 for the default)
- CELL_H_LOG2, 3, log2 cell height in pixels
- DATA_W, 8, character code width
- FILL_CHAR, 0, code written by the clear command

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- hpos  in  10  horizontal position from hvsync_generator
- vpos  in  10  vertical position from hvsync_generator
- display_on  in  1  active-video flag
- wr_valid  in  1  host command valid
- wr_ready  out  1  command accepted this cycle when wr_valid && wr_ready
- wr_cmd  in  2  00 = put char, 01 = set column, 10 = set row, 11 = clear screen
- wr_data  in  DATA_W  char code or cursor coordinate
- busy  out  1  clear engine active
- glyph_code  out  DATA_W  char code to glyph ROM
- glyph_yofs  out  CELL_H_LOG2  scanline within cell to glyph ROM
- glyph_bits  in  2^CELL_W_LOG2  glyph ROM row, combinational from glyph_code/glyph_yofs; MSB = leftmost pixel
- pixel  out  1  registered pixel

Behaviour:
- Reset: pixel=0, busy=0, cursor row=0 col=0, state=IDLE, blink counter=0. wr_ready is combinational and therefore 0 while display_on=1. RAM contents are not reset.
- Cell coordinates: col = hpos>>CELL_W_LOG2, row = vpos>>CELL_H_LOG2.
- RAM: ROWS*COLS words of DATA_W, synchronous read, one port. Address = row*COLS+col.
- Display pipeline:
  - cycle t: address from hpos/vpos.
  - t+1: glyph_code = RAM dout; glyph_yofs and the x offset are delayed one cycle to match.
  - t+2: pixel = display_on_d1 && in_grid_d1 && glyph_bits[2^CELL_W_LOG2-1-xofs_d1].
- in_grid = (col < COLS) && (row < ROWS). Outside the grid, pixel=0 and RAM dout is ignored.
- Port arbitration: the display owns the RAM while display_on=1. Host writes and clear writes happen only when display_on=0.
- FSM IDLE:
  - wr_ready = !display_on.
  - On accept, by wr_cmd:
    - 00: write wr_data at cursor, then advance the cursor. col+1; if col==COLS-1, col=0 and row+1; if row==ROWS-1 as well, row=0 (wrap, no scroll).
    - 01: col = min(wr_data, COLS-1).
    - 10: row = min(wr_data, ROWS-1).
    - 11: go to CLEAR with clr_addr=0 and busy=1 from the next cycle. The cursor resets to 0,0.
- FSM CLEAR:
  - wr_ready=0.
  - Each cycle with display_on=0, write FILL_CHAR at clr_addr and increment it. No writes while display_on=1; the engine pauses.
  - After writing address ROWS*COLS-1, return to IDLE and busy=0 the next cycle.
- Simultaneous events: if wr_valid is asserted as display_on rises, no accept occurs (wr_ready=0); the command is held by the host.
- Reset mid-clear: aborts immediately to IDLE and leaves partial RAM contents.
- All arithmetic uses widths sized by $clog2 of COLS, ROWS and ROWS*COLS. Cursor increments never exceed the bounds above.

Optional Feature:
- Macro: TEXT_GRID_CURSOR_BLINK_EN.
- When defined:
  - A 5-bit frame counter increments on the cycle hpos==0 && vpos==0.
  - While counter[4]=1, pixel is inverted for the cell at the cursor position, inside the grid with display_on only.
  - The counter resets to 0.
- When undefined: no counter and no inversion; pixel is exactly as above.

Test Plan:
- Reset, then sweep a frame with glyph_bits=8'hFF -> pixel=0 everywhere outside the grid (col>=COLS or row>=ROWS); pixel appears 2 cycles after hpos enters the grid.
- Put char 0x05 with cursor at 0,0 during blanking -> at hpos=0..7, vpos=0..7 of the next frame glyph_code=0x05; cursor col=1.
- Set col=31, row=29, put char ×2 -> first write lands at address 29*32+31=959; the cursor wraps to 0,0 and the second char is at address 0.
- Set col=200 -> clamped to col=31; the next put char lands at row*32+31.
- Clear with FILL_CHAR=0 -> busy=1; writes only with display_on=0; busy drops after 960 writes; all cells read 0; the cursor is at 0,0; wr_ready=0 throughout.
- Pulse reset mid-clear -> busy=0 the next cycle and wr_ready follows !display_on. With TEXT_GRID_CURSOR_BLINK_EN, frames 16..31 show the cursor cell inverted.

Source files
------------

// File: rtl/text_grid_display.sv
// text_grid_display: character-cell text display with an internal single-port
// character RAM, host command port with cursor auto-advance and a clear engine.
// Optional build macro: TEXT_GRID_CURSOR_BLINK_EN (inverts the cursor cell on
// alternate 16-frame periods).
module text_grid_display #(
    parameter int unsigned          COLS        = 32,
    parameter int unsigned          ROWS        = 30,
    parameter int unsigned          CELL_W_LOG2 = 3,
    parameter int unsigned          CELL_H_LOG2 = 3,
    parameter int unsigned          DATA_W      = 8,
    parameter logic [DATA_W-1:0]    FILL_CHAR   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    hpos,
    input  logic [9:0]                    vpos,
    input  logic                          display_on,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [1:0]                    wr_cmd,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          busy,
    output logic [DATA_W-1:0]             glyph_code,
    output logic [CELL_H_LOG2-1:0]        glyph_yofs,
    input  logic [(1<<CELL_W_LOG2)-1:0]   glyph_bits,
    output logic                          pixel
);

    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned COL_W  = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int unsigned ROW_W  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int unsigned ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] CMD_PUT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_ROW = 2'b10;
    localparam logic [1:0] CMD_CLR = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state;
    logic [COL_W-1:0]         cur_col;
    logic [ROW_W-1:0]         cur_row;
    logic [ADDR_W-1:0]        clr_addr;

    logic [9:0]               col_raw;
    logic [9:0]               row_raw;
    logic                     in_grid;
    logic [ADDR_W-1:0]        disp_addr;
    logic [ADDR_W-1:0]        cur_addr;
    logic                     accept;
    logic [COL_W-1:0]         col_clamp;
    logic [ROW_W-1:0]         row_clamp;
    logic                     inv_c;

    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        mem [CELLS];

    logic                     don_d1;
    logic                     ig_d1;
    logic                     inv_d1;
    logic [CELL_W_LOG2-1:0]   xofs_d1;

    // Beam position to cell coordinates and RAM address
    assign col_raw   = hpos >> CELL_W_LOG2;
    assign row_raw   = vpos >> CELL_H_LOG2;
    assign in_grid   = (32'(col_raw) < COLS) && (32'(row_raw) < ROWS);
    assign disp_addr = in_grid ? ADDR_W'(32'(row_raw) * COLS + 32'(col_raw)) : '0;
    assign cur_addr  = ADDR_W'(32'(cur_row) * COLS + 32'(cur_col));

    // Host handshake: only idle and only while the display is not using the RAM
    assign wr_ready  = (state == IDLE) && !display_on && !reset;
    assign accept    = wr_valid && wr_ready;

    // Cursor coordinate clamping for set-column / set-row commands
    assign col_clamp = (32'(wr_data) >= COLS) ? COL_W'(COLS - 1) : COL_W'(wr_data);
    assign row_clamp = (32'(wr_data) >= ROWS) ? ROW_W'(ROWS - 1) : ROW_W'(wr_data);

`ifdef TEXT_GRID_CURSOR_BLINK_EN
    logic [4:0] blink_cnt;

    // Frame counter, stepped once per frame at the top-left beam position
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
        end else if (hpos == 10'd0 && vpos == 10'd0) begin
            blink_cnt <= blink_cnt + 5'd1;
        end
    end

    assign inv_c = blink_cnt[4] && (col_raw == 10'(cur_col)) && (row_raw == 10'(cur_row));
`else
    assign inv_c = 1'b0;
`endif

    // Single RAM port: display reads unless a host or clear write is due
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = wr_data;
        if (!reset && !display_on) begin
            if (state == CLEAR) begin
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = FILL_CHAR;
            end else if (accept && wr_cmd == CMD_PUT) begin
                ram_we    = 1'b1;
                ram_addr  = cur_addr;
            end
        end
    end

    // Character RAM with synchronous read; read data is the glyph code
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        glyph_code <= mem[ram_addr];
    end

    // Command FSM: cursor handling and the clear engine
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cur_col  <= '0;
            cur_row  <= '0;
            clr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (wr_cmd)
                            CMD_PUT: begin
                                if (cur_col == COL_W'(COLS - 1)) begin
                                    cur_col <= '0;
                                    if (cur_row == ROW_W'(ROWS - 1)) begin
                                        cur_row <= '0;
                                    end else begin
                                        cur_row <= cur_row + ROW_W'(1);
                                    end
                                end else begin
                                    cur_col <= cur_col + COL_W'(1);
                                end
                            end
                            CMD_COL: cur_col <= col_clamp;
                            CMD_ROW: cur_row <= row_clamp;
                            CMD_CLR: begin
                                state    <= CLEAR;
                                busy     <= 1'b1;
                                clr_addr <= '0;
                                cur_col  <= '0;
                                cur_row  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (!display_on) begin
                        if (clr_addr == ADDR_W'(CELLS - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display pipeline: delay beam attributes to line up with the RAM read
    always_ff @(posedge clk) begin
        if (reset) begin
            don_d1     <= 1'b0;
            ig_d1      <= 1'b0;
            inv_d1     <= 1'b0;
            xofs_d1    <= '0;
            glyph_yofs <= '0;
            pixel      <= 1'b0;
        end else begin
            don_d1     <= display_on;
            ig_d1      <= in_grid;
            inv_d1     <= inv_c;
            xofs_d1    <= hpos[CELL_W_LOG2-1:0];
            glyph_yofs <= vpos[CELL_H_LOG2-1:0];
            pixel      <= don_d1 && ig_d1 && (glyph_bits[~xofs_d1] ^ inv_d1);
        end
    end

endmodule

// File: tb/tb_text_grid_display.sv
// Bench for text_grid_display (default parameters). Acts as the glyph ROM and
// the beam source, and checks against a cell-array / cursor reference model.
module tb_text_grid_display;

    localparam int COLS  = 32;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_cmd;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] glyph_code;
    logic [2:0] glyph_yofs;
    logic [7:0] glyph_bits;
    logic       pixel;

    int  model_mem [CELLS];
    int  cur_r;
    int  cur_c;
    int  blink_cnt;
    int  n_checks;
    int  n_fail;
    bit  force_ff;
    int  sh[$];
    int  sv[$];
    int  sd[$];

    text_grid_display dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_cmd     (wr_cmd),
        .wr_data    (wr_data),
        .busy       (busy),
        .glyph_code (glyph_code),
        .glyph_yofs (glyph_yofs),
        .glyph_bits (glyph_bits),
        .pixel      (pixel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] code, input logic [2:0] y);
        int v;
        v = (int'(code) * 37) ^ (int'(y) * 29) ^ 'h5A;
        return 8'(v);
    endfunction

    assign glyph_bits = force_ff ? 8'hFF : rom(glyph_code, glyph_yofs);

    // Expected pixel for a beam position: -1 when the cell content is unknown
    function automatic int exp_pixel(input int h, input int v, input int don);
        int c, r, bits, b;
        c = h >> 3;
        r = v >> 3;
        if (don == 0 || c >= COLS || r >= ROWS) return 0;
        if (force_ff) bits = 255;
        else if (model_mem[r*COLS+c] < 0) return -1;
        else bits = int'(rom(8'(model_mem[r*COLS+c]), 3'(v & 7)));
        b = (bits >> (7 - (h & 7))) & 1;
`ifdef TEXT_GRID_CURSOR_BLINK_EN
        if (blink_cnt >= 16 && r == cur_r && c == cur_c) b = b ^ 1;
`endif
        return b;
    endfunction

    task automatic tick();
`ifdef TEXT_GRID_CURSOR_BLINK_EN
        if (reset) blink_cnt = 0;
        else if (hpos == 10'd0 && vpos == 10'd0) blink_cnt = (blink_cnt + 1) % 32;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        hpos = 10'd700;
        vpos = 10'd500;
        display_on = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic add_cell(input int r, input int c);
        sh.push_back(c * 8 + int'($urandom_range(0, 7)));
        sv.push_back(r * 8 + int'($urandom_range(0, 7)));
        sd.push_back(1);
    endtask

    // Drive the queued beam positions and check glyph_code / glyph_yofs / pixel
    task automatic run_scan(input string name);
        int p_exp;
        int e_pix;
        int e_code;
        int e_y;
        p_exp = -2;
        for (int i = 0; i <= sh.size(); i++) begin
            e_pix = -2;
            e_code = -1;
            e_y = 0;
            if (i < sh.size()) begin
                hpos = 10'(sh[i]);
                vpos = 10'(sv[i]);
                display_on = sd[i] != 0;
                e_pix = exp_pixel(sh[i], sv[i], sd[i]);
                e_y = sv[i] & 7;
                if (sd[i] != 0 && (sh[i] >> 3) < COLS && (sv[i] >> 3) < ROWS)
                    e_code = model_mem[(sv[i] >> 3) * COLS + (sh[i] >> 3)];
            end else begin
                park();
            end
            tick();
            if (e_code >= 0) begin
                n_checks++;
                if (int'(glyph_code) !== e_code || int'(glyph_yofs) !== e_y) begin
                    n_fail++;
                    $display("FAIL %s glyph h=%0d v=%0d: code=%0d yofs=%0d, expected code=%0d yofs=%0d",
                             name, sh[i], sv[i], glyph_code, glyph_yofs, e_code, e_y);
                end
            end
            if (p_exp >= 0) begin
                n_checks++;
                if (int'(pixel) !== p_exp) begin
                    n_fail++;
                    $display("FAIL %s pixel h=%0d v=%0d: got %0d, expected %0d",
                             name, sh[i-1], sv[i-1], pixel, p_exp);
                end
            end
            p_exp = e_pix;
        end
        sh.delete();
        sv.delete();
        sd.delete();
        park();
    endtask

    // Issue one host command during blanking; it must be accepted immediately
    task automatic send_cmd(input int cmd, input int data);
        int idx;
        display_on = 1'b0;
        wr_valid = 1'b1;
        wr_cmd = 2'(cmd);
        wr_data = 8'(data);
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_cmd wr_ready: got %b, expected 1 (cmd=%0d)", wr_ready, cmd);
        end
        tick();
        wr_valid = 1'b0;
        case (cmd)
            0: begin
                model_mem[cur_r*COLS+cur_c] = data & 255;
                idx = (cur_r * COLS + cur_c + 1) % CELLS;
                cur_r = idx / COLS;
                cur_c = idx % COLS;
            end
            1: cur_c = (data > COLS - 1) ? COLS - 1 : data;
            2: cur_r = (data > ROWS - 1) ? ROWS - 1 : data;
            default: begin
                cur_r = 0;
                cur_c = 0;
            end
        endcase
    endtask

    task automatic test_reset();
        park();
        reset = 1'b1;
        display_on = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pixel !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pixel=%b busy=%b wr_ready=%b, expected 0 0 0", pixel, busy, wr_ready);
        end
        reset = 1'b0;
        display_on = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: wr_ready=%b, expected 1", wr_ready);
        end
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic test_outside_grid();
        int edges_h[4] = '{COLS*8-1, COLS*8, 0, 1023};
        int edges_v[4] = '{ROWS*8-1, ROWS*8, 0, 1023};
        force_ff = 1'b1;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                sh.push_back(edges_h[a]);
                sv.push_back(edges_v[b]);
                sd.push_back(1);
            end
        for (int i = 0; i < 200; i++) begin
            sh.push_back(int'($urandom_range(0, 1023)));
            sv.push_back(int'($urandom_range(0, 1023)));
            sd.push_back(int'($urandom_range(0, 3) != 0));
        end
        run_scan("outside_grid");
        force_ff = 1'b0;
    endtask

    task automatic test_put_char();
        send_cmd(0, 8'h05);
        for (int v = 0; v < 8; v++)
            for (int h = 0; h < 8; h++) begin
                sh.push_back(h);
                sv.push_back(v);
                sd.push_back(1);
            end
        run_scan("put_char_cell00");
        send_cmd(0, 8'h33);
        add_cell(0, 1);
        add_cell(0, 0);
        run_scan("put_char_advance");
    endtask

    task automatic test_wrap();
        send_cmd(1, 31);
        send_cmd(2, 29);
        send_cmd(0, 8'h41);
        send_cmd(0, 8'h42);
        add_cell(29, 31);
        add_cell(0, 0);
        add_cell(0, 1);
        run_scan("wrap");
    endtask

    task automatic test_clamp();
        int r;
        r = int'($urandom_range(0, ROWS - 1));
        send_cmd(2, r);
        send_cmd(1, 200);
        send_cmd(0, 8'h77);
        send_cmd(1, 0);
        send_cmd(2, 255);
        send_cmd(0, 8'h78);
        add_cell(r, 31);
        add_cell(29, 0);
        run_scan("clamp");
    endtask

    task automatic test_clear();
        int writes;
        int cyc;
        bit ok;
        send_cmd(3, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_start busy: got %b, expected 1", busy);
        end
        writes = 0;
        cyc = 0;
        ok = 1'b1;
        while (ok && writes < CELLS && cyc < 5000) begin
            display_on = $urandom_range(0, 2) == 0;
            if (display_on) begin
                hpos = 10'($urandom_range(0, 1023));
                vpos = 10'($urandom_range(0, 1023));
            end else begin
                hpos = 10'd700;
                vpos = 10'd500;
            end
            wr_valid = 1'b1;
            wr_cmd = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom_range(0, 255));
            #1;
            n_checks++;
            if (wr_ready !== 1'b0) begin
                n_fail++;
                ok = 1'b0;
                $display("FAIL clear_ready: wr_ready=%b during clear, expected 0", wr_ready);
            end
            if (!display_on) writes++;
            tick();
            n_checks++;
            if (busy !== (writes < CELLS)) begin
                n_fail++;
                ok = 1'b0;
                $display("FAIL clear_busy after %0d writes: busy=%b, expected %b", writes, busy, writes < CELLS);
            end
            cyc++;
        end
        park();
        if (cyc >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL clear_timeout: busy=%b after %0d cycles, expected 0", busy, cyc);
        end
        for (int i = 0; i < CELLS; i++) model_mem[i] = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) add_cell(r, c);
        run_scan("clear_contents");
        send_cmd(0, 8'hC3);
        add_cell(0, 0);
        add_cell(0, 1);
        run_scan("clear_cursor");
    endtask

    task automatic test_held_cmd();
        send_cmd(2, 7);
        send_cmd(1, 3);
        wr_valid = 1'b1;
        wr_cmd = 2'b00;
        wr_data = 8'h99;
        display_on = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_ready: wr_ready=%b with display_on, expected 0", wr_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        wr_valid = 1'b0;
        send_cmd(0, 8'h99);
        send_cmd(0, 8'h9A);
        add_cell(7, 3);
        add_cell(7, 4);
        add_cell(7, 5);
        run_scan("held_cmd");
    endtask

    task automatic test_back_to_back();
        int cmd;
        for (int i = 0; i < 60; i++) begin
            cmd = int'($urandom_range(0, 2));
            if (cmd == 0) send_cmd(0, int'($urandom_range(0, 255)));
            else send_cmd(cmd, int'($urandom_range(0, 80)));
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) add_cell(r, c);
        run_scan("back_to_back");
    endtask

    task automatic test_reset_mid_clear();
        send_cmd(2, 2);
        send_cmd(1, 31);
        for (int i = 0; i < 10; i++) send_cmd(0, int'($urandom_range(1, 255)));
        send_cmd(3, 0);
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b, expected 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_reset busy: got %b, expected 0", busy);
        end
        display_on = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_ready_on: wr_ready=%b, expected 0", wr_ready);
        end
        display_on = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_ready_off: wr_ready=%b, expected 1", wr_ready);
        end
        for (int i = 0; i < 100; i++) model_mem[i] = 0;
        cur_r = 0;
        cur_c = 0;
        for (int a = 90; a < 110; a++) add_cell(a / COLS, a % COLS);
        run_scan("midclear_contents");
        send_cmd(0, 8'h11);
        add_cell(0, 0);
        run_scan("midclear_cursor");
    endtask

`ifdef TEXT_GRID_CURSOR_BLINK_EN
    task automatic test_blink();
        send_cmd(2, 3);
        send_cmd(1, 5);
        for (int k = 0; k < 3; k++) begin
            add_cell(3, 5);
            add_cell(3, 6);
            add_cell(3, 5);
            run_scan("blink");
            for (int i = 0; i < 16; i++) begin
                hpos = 10'd0;
                vpos = 10'd0;
                display_on = 1'b1;
                tick();
            end
            park();
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        blink_cnt = 0;
        force_ff = 1'b0;
        wr_cmd = 2'b00;
        wr_data = 8'h00;
        reset = 1'b1;
        for (int i = 0; i < CELLS; i++) model_mem[i] = -1;
        park();
        test_reset();
        test_outside_grid();
        test_put_char();
        test_wrap();
        test_clamp();
        test_clear();
        test_held_cmd();
        test_back_to_back();
        test_reset_mid_clear();
`ifdef TEXT_GRID_CURSOR_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
